// File: rtl/prescaled_mode_counter.sv
`default_nettype none
// ============================================================================
//  Module      : prescaled_mode_counter
//  Description : Free-running display counter advanced by an integrated
//                clock-enable prescaler. Supports up / down / bounce / hold
//                modes, a synchronous load and registered tick/wrap pulses.
//                Optional build macro GRAY_OUT_EN presents count_value in
//                Gray code; internal arithmetic and load_value stay binary.
//  Revision    : 1.0  initial release
// ============================================================================
module prescaled_mode_counter #(
    parameter int WIDTH = 4,        // count width in bits (>=2)
    parameter int DIV   = 2097152,  // clock cycles per count step (>=1)
    parameter int DIV_W = 21        // prescaler width, 2**DIV_W >= DIV
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             EN_step,
    input  logic [1:0]       mode,
    input  logic             EN_load,
    input  logic [WIDTH-1:0] load_value,
    output logic [WIDTH-1:0] count_value,
    output logic             RDY_count_value,
    output logic             tick,
    output logic             wrap
);

    localparam logic [DIV_W-1:0] C_PSC_LAST   = DIV_W'(DIV - 1);
    localparam logic [WIDTH-1:0] C_CNT_MAX    = '1;
    localparam logic [WIDTH-1:0] C_CNT_ONE    = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [1:0]       C_MODE_UP    = 2'b00;
    localparam logic [1:0]       C_MODE_DOWN  = 2'b01;
    localparam logic [1:0]       C_MODE_BOUNCE= 2'b10;
    localparam logic             C_DIR_UP     = 1'b0;
    localparam logic             C_DIR_DOWN   = 1'b1;

    logic [DIV_W-1:0] psc_q, psc_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic             dir_q, dir_d;
    logic             tick_q;
    logic             wrap_q, wrap_d;
    logic             rdy_q;
    logic             step_w;

    // Prescaler: counts enabled cycles and flags a step on the last one of each DIV group
    always_comb begin
        psc_d  = psc_q;
        step_w = 1'b0;
        if (EN_step) begin
            if (psc_q == C_PSC_LAST) begin
                psc_d  = '0;
                step_w = 1'b1;
            end else begin
                psc_d  = psc_q + 1'b1;
            end
        end
    end

    // Count/direction next state; a load discards any coincident step
    always_comb begin
        count_d = count_q;
        dir_d   = dir_q;
        wrap_d  = 1'b0;
        if (EN_load) begin
            count_d = load_value;
        end else if (step_w) begin
            case (mode)
                C_MODE_UP: begin
                    count_d = count_q + 1'b1;
                    wrap_d  = (count_q == C_CNT_MAX);
                end
                C_MODE_DOWN: begin
                    count_d = count_q - 1'b1;
                    wrap_d  = (count_q == '0);
                end
                C_MODE_BOUNCE: begin
                    // Reversal moves one step away from the endpoint so the count never dwells there
                    if (dir_q == C_DIR_UP) begin
                        if (count_q == C_CNT_MAX) begin
                            count_d = C_CNT_MAX - 1'b1;
                            dir_d   = C_DIR_DOWN;
                            wrap_d  = 1'b1;
                        end else begin
                            count_d = count_q + 1'b1;
                        end
                    end else begin
                        if (count_q == '0) begin
                            count_d = C_CNT_ONE;
                            dir_d   = C_DIR_UP;
                            wrap_d  = 1'b1;
                        end else begin
                            count_d = count_q - 1'b1;
                        end
                    end
                end
                default: begin
                    count_d = count_q;
                end
            endcase
        end
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            psc_q   <= '0;
            count_q <= '0;
            dir_q   <= C_DIR_UP;
            tick_q  <= 1'b0;
            wrap_q  <= 1'b0;
            rdy_q   <= 1'b0;
        end else begin
            psc_q   <= psc_d;
            count_q <= count_d;
            dir_q   <= dir_d;
            tick_q  <= step_w;
            wrap_q  <= wrap_d;
            rdy_q   <= 1'b1;
        end
    end

`ifdef GRAY_OUT_EN
    assign count_value = count_q ^ (count_q >> 1);
`else
    assign count_value = count_q;
`endif

    assign tick            = tick_q;
    assign wrap            = wrap_q;
    assign RDY_count_value = rdy_q;

endmodule
`default_nettype wire

// File: tb/tb_prescaled_mode_counter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_prescaled_mode_counter
//  Description : Self-checking bench for prescaled_mode_counter (WIDTH=4,
//                DIV=4): directed vector table, hand-written corner sequences
//                and randomized traffic against a behavioural model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_prescaled_mode_counter;

    localparam int WIDTH = 4;
    localparam int DIV   = 4;
    localparam int DIV_W = 2;
    localparam int MAXV  = (1 << WIDTH) - 1;

    logic             clk   = 1'b0;
    logic             rst_n = 1'b0;
    logic             en    = 1'b0;
    logic [1:0]       mode  = 2'b00;
    logic             ld    = 1'b0;
    logic [WIDTH-1:0] lv    = '0;
    logic [WIDTH-1:0] count_value;
    logic             rdy;
    logic             tick;
    logic             wrap;

    int checks   = 0;
    int failures = 0;

    // Behavioural model state
    int m_en_cycles;
    int m_count;
    int m_dir;
    int m_tick;
    int m_wrap;
    int m_rdy;

    prescaled_mode_counter #(
        .WIDTH (WIDTH),
        .DIV   (DIV),
        .DIV_W (DIV_W)
    ) dut (
        .CLK             (clk),
        .RST_N           (rst_n),
        .EN_step         (en),
        .mode            (mode),
        .EN_load         (ld),
        .load_value      (lv),
        .count_value     (count_value),
        .RDY_count_value (rdy),
        .tick            (tick),
        .wrap            (wrap)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       en;
        logic [1:0] mode;
        logic       ld;
        logic [3:0] lv;
        int         exp_count;
        int         exp_tick;
        int         exp_wrap;
    } vec_t;

    vec_t tbl[20];

    function automatic vec_t mk(logic e, logic [1:0] m, logic l, logic [3:0] v,
                                int c, int t, int w);
        vec_t r;
        r.en = e; r.mode = m; r.ld = l; r.lv = v;
        r.exp_count = c; r.exp_tick = t; r.exp_wrap = w;
        return r;
    endfunction

    // Expected presentation of a binary count on count_value
    function automatic int disp(int c);
        logic [WIDTH-1:0] b;
        b = WIDTH'(c);
`ifdef GRAY_OUT_EN
        b = b ^ (b >> 1);
`endif
        return int'(b);
    endfunction

    task automatic check(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_en_cycles = 0;
        m_count     = 0;
        m_dir       = 1;
        m_tick      = 0;
        m_wrap      = 0;
        m_rdy       = 0;
    endfunction

    // One clock edge of the specified behaviour: every DIV-th enabled cycle is a step
    function automatic void model_edge();
        int step;
        int nxt;
        step = 0;
        if (en) begin
            m_en_cycles++;
            step = ((m_en_cycles % DIV) == 0) ? 1 : 0;
        end
        m_tick = step;
        m_wrap = 0;
        if (ld) begin
            m_count = int'(lv);
        end else if (step != 0) begin
            case (int'(mode))
                0: begin
                    nxt     = m_count + 1;
                    m_wrap  = (nxt > MAXV) ? 1 : 0;
                    m_count = nxt % (MAXV + 1);
                end
                1: begin
                    nxt     = m_count - 1;
                    m_wrap  = (nxt < 0) ? 1 : 0;
                    m_count = (nxt + MAXV + 1) % (MAXV + 1);
                end
                2: begin
                    nxt = m_count + m_dir;
                    if (nxt > MAXV || nxt < 0) begin
                        m_dir  = -m_dir;
                        nxt    = m_count + m_dir;
                        m_wrap = 1;
                    end
                    m_count = nxt;
                end
                default: ;
            endcase
        end
        m_rdy = 1;
    endfunction

    task automatic compare_model();
        check("model_count", int'(count_value), disp(m_count));
        check("model_tick",  int'(tick), m_tick);
        check("model_wrap",  int'(wrap), m_wrap);
        check("model_rdy",   int'(rdy),  m_rdy);
    endtask

    // Advance one clock; inputs must already be applied
    task automatic cyc();
        @(posedge clk);
        if (rst_n) model_edge();
        else       model_reset();
        #1;
        compare_model();
    endtask

    task automatic run_to_tick(output int n);
        n = 0;
        do begin
            cyc();
            n++;
        end while (!tick && n < 64);
        if (!tick) begin
            failures++;
            $display("FAIL tick_timeout: got no tick required tick within 64 cycles");
        end
    endtask

    initial begin
        int n;
        model_reset();

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("reset_count", int'(count_value), disp(0));
        check("reset_tick",  int'(tick), 0);
        check("reset_wrap",  int'(wrap), 0);
        check("reset_rdy",   int'(rdy),  0);
        rst_n = 1'b1;

        // Directed table: load, up-count with wrap, load/step collision, start of gating
        tbl[0]  = mk(0, 2'b00, 0, 4'd0,  0,  0, 0);
        tbl[1]  = mk(0, 2'b00, 1, 4'd14, 14, 0, 0);
        tbl[2]  = mk(1, 2'b00, 0, 4'd0,  14, 0, 0);
        tbl[3]  = mk(1, 2'b00, 0, 4'd0,  14, 0, 0);
        tbl[4]  = mk(1, 2'b00, 0, 4'd0,  14, 0, 0);
        tbl[5]  = mk(1, 2'b00, 0, 4'd0,  15, 1, 0);
        tbl[6]  = mk(1, 2'b00, 0, 4'd0,  15, 0, 0);
        tbl[7]  = mk(1, 2'b00, 0, 4'd0,  15, 0, 0);
        tbl[8]  = mk(1, 2'b00, 0, 4'd0,  15, 0, 0);
        tbl[9]  = mk(1, 2'b00, 0, 4'd0,  0,  1, 1);
        tbl[10] = mk(1, 2'b00, 0, 4'd0,  0,  0, 0);
        tbl[11] = mk(1, 2'b00, 0, 4'd0,  0,  0, 0);
        tbl[12] = mk(1, 2'b00, 0, 4'd0,  0,  0, 0);
        tbl[13] = mk(1, 2'b00, 1, 4'd9,  9,  1, 0);
        tbl[14] = mk(1, 2'b00, 0, 4'd0,  9,  0, 0);
        tbl[15] = mk(1, 2'b00, 0, 4'd0,  9,  0, 0);
        tbl[16] = mk(1, 2'b00, 0, 4'd0,  9,  0, 0);
        tbl[17] = mk(1, 2'b00, 0, 4'd0,  10, 1, 0);
        tbl[18] = mk(1, 2'b00, 0, 4'd0,  10, 0, 0);
        tbl[19] = mk(1, 2'b00, 0, 4'd0,  10, 0, 0);
        for (int i = 0; i < 20; i++) begin
            en = tbl[i].en; mode = tbl[i].mode; ld = tbl[i].ld; lv = tbl[i].lv;
            cyc();
            check($sformatf("vec%0d_count", i), int'(count_value), disp(tbl[i].exp_count));
            check($sformatf("vec%0d_tick", i),  int'(tick), tbl[i].exp_tick);
            check($sformatf("vec%0d_wrap", i),  int'(wrap), tbl[i].exp_wrap);
            check($sformatf("vec%0d_rdy", i),   int'(rdy), 1);
        end

        // Enable gating with prescaler at 2: frozen for 10 cycles, step 2 cycles after re-enable
        en = 1'b0;
        for (int i = 0; i < 10; i++) begin
            cyc();
            check("gate_tick",  int'(tick), 0);
            check("gate_count", int'(count_value), disp(10));
        end
        en = 1'b1;
        cyc();
        check("reenable_1_tick", int'(tick), 0);
        cyc();
        check("reenable_2_tick",  int'(tick), 1);
        check("reenable_2_count", int'(count_value), disp(11));

        // Down from 0 wraps to max
        mode = 2'b01; ld = 1'b1; lv = 4'd0;
        cyc();
        ld = 1'b0;
        run_to_tick(n);
        check("down_count", int'(count_value), disp(MAXV));
        check("down_wrap",  int'(wrap), 1);

        // Hold: count frozen, tick every DIV cycles
        mode = 2'b11;
        run_to_tick(n);
        check("hold_count", int'(count_value), disp(MAXV));
        check("hold_wrap",  int'(wrap), 0);
        run_to_tick(n);
        check("hold_interval", n, DIV);

        // Bounce from 14 going up: 15, 14 (wrap) ... 0, 1 (wrap)
        mode = 2'b10; ld = 1'b1; lv = 4'd14;
        cyc();
        ld = 1'b0;
        for (int k = 1; k <= 17; k++) begin
            run_to_tick(n);
            check($sformatf("bounce%0d_count", k), int'(count_value),
                  disp((k == 1) ? 15 : ((k == 17) ? 1 : 16 - k)));
            check($sformatf("bounce%0d_wrap", k), int'(wrap), (k == 2 || k == 17) ? 1 : 0);
        end

        // Randomized traffic with occasional asynchronous mid-cycle resets
        for (int i = 0; i < 3000; i++) begin
            en   = ($urandom_range(0, 3) != 0);
            mode = 2'($urandom);
            ld   = ($urandom_range(0, 9) == 0);
            lv   = WIDTH'($urandom);
            if ($urandom_range(0, 199) == 0) begin
                #3;
                rst_n = 1'b0;
                #1;
                model_reset();
                check("async_reset_count", int'(count_value), disp(0));
                check("async_reset_tick",  int'(tick), 0);
                check("async_reset_wrap",  int'(wrap), 0);
                check("async_reset_rdy",   int'(rdy),  0);
                cyc();
                rst_n = 1'b1;
                cyc();
                check("rdy_after_release", int'(rdy), 1);
            end else begin
                cyc();
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
